// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Function : Round-robin sharing of one UART TX core between NUM_REQ byte
//            sources. Each byte is held for one paced character slot.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int OVER_SAMPLING = 4,
    parameter int GUARD_CYCLES  = 4,
    parameter int DE_CYCLES     = 2
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   iSEVEN_BIT,
    input  logic                   iPARITY_EN,
    input  logic                   iSTOP_BIT,
    input  logic [NUM_REQ-1:0]     iREQ,
    input  logic [8*NUM_REQ-1:0]   iDATA,
    output logic [NUM_REQ-1:0]     oACK,
    output logic                   oTX_DE,
    output logic [7:0]             oTX_DATA,
    output logic                   oBUSY
);

    localparam int c_CNT_W = $clog2(12*OVER_SAMPLING + GUARD_CYCLES) + 1;
    localparam int c_PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_SEND = 1'b1;

    localparam logic [c_PW-1:0] c_PTR_RST = c_PW'(NUM_REQ - 1);
    localparam logic [1:0]      c_DE_INIT = 2'(DE_CYCLES - 1);

    logic [0:0]          r_state, w_state_nxt;
    logic [NUM_REQ-1:0]  r_ack, w_ack_nxt;
    logic                r_de, w_de_nxt;
    logic [7:0]          r_data, w_data_nxt;
    logic                r_busy, w_busy_nxt;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [1:0]          r_de_cnt, w_de_cnt_nxt;
    logic [c_PW-1:0]     r_ptr, w_ptr_nxt;

    logic                w_any;
    logic [c_PW-1:0]     w_win;
    logic [7:0]          w_win_data;
    int                  w_idx;
    logic [3:0]          w_bits;
    logic [c_CNT_W-1:0]  w_slot;

    // Character length in bits: start + data + optional parity + stop(s)
    always_comb begin
        w_bits = 4'd1 + (iSEVEN_BIT ? 4'd7 : 4'd8) + {3'b000, iPARITY_EN}
               + (iSTOP_BIT ? 4'd2 : 4'd1);
        w_slot = c_CNT_W'(w_bits) * c_CNT_W'(OVER_SAMPLING) + c_CNT_W'(GUARD_CYCLES);
    end

    // Search starts one past the last winner so every requester gets a turn
    always_comb begin
        w_any      = 1'b0;
        w_win      = '0;
        w_win_data = 8'hFF;
        w_idx      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_any && iREQ[w_idx]) begin
                w_any      = 1'b1;
                w_win      = c_PW'(w_idx);
                w_win_data = iDATA[8*w_idx +: 8];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= c_IDLE;
            r_ack    <= '0;
            r_de     <= 1'b0;
            r_data   <= 8'hFF;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_de_cnt <= '0;
            r_ptr    <= c_PTR_RST;
        end else begin
            r_state  <= w_state_nxt;
            r_ack    <= w_ack_nxt;
            r_de     <= w_de_nxt;
            r_data   <= w_data_nxt;
            r_busy   <= w_busy_nxt;
            r_cnt    <= w_cnt_nxt;
            r_de_cnt <= w_de_cnt_nxt;
            r_ptr    <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_any) w_state_nxt = c_SEND;
            c_SEND:  if (r_cnt == '0) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_ack_nxt    = '0;
        w_de_nxt     = r_de;
        w_data_nxt   = r_data;
        w_busy_nxt   = r_busy;
        w_cnt_nxt    = r_cnt;
        w_de_cnt_nxt = r_de_cnt;
        w_ptr_nxt    = r_ptr;
        case (r_state)
            c_IDLE: begin
                w_de_nxt   = 1'b0;
                w_busy_nxt = 1'b0;
                if (w_any) begin
                    w_ack_nxt[w_win] = 1'b1;
                    w_data_nxt       = w_win_data;
                    w_de_nxt         = 1'b1;
                    w_de_cnt_nxt     = c_DE_INIT;
                    w_cnt_nxt        = w_slot - c_CNT_W'(1);
                    w_ptr_nxt        = w_win;
                    w_busy_nxt       = 1'b1;
                end
            end
            c_SEND: begin
                w_cnt_nxt = r_cnt - c_CNT_W'(1);
                // DE drops early so the core always sees a fresh rising edge
                if (r_de_cnt == 2'd0) begin
                    w_de_nxt = 1'b0;
                end else begin
                    w_de_cnt_nxt = r_de_cnt - 2'd1;
                end
                if (r_cnt == '0) begin
                    w_cnt_nxt  = '0;
                    w_de_nxt   = 1'b0;
                    w_busy_nxt = 1'b0;
                end
            end
            default: begin
                w_de_nxt   = 1'b0;
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    assign oACK     = r_ack;
    assign oTX_DE   = r_de;
    assign oTX_DATA = r_data;
    assign oBUSY    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Function : Directed-vector bench for uart_tx_arbiter (2 requesters).
// Revision : 1.0
// ============================================================================
module tb_uart_tx_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        iSEVEN_BIT, iPARITY_EN, iSTOP_BIT;
    logic [1:0]  iREQ;
    logic [15:0] iDATA;
    logic [1:0]  oACK;
    logic        oTX_DE;
    logic [7:0]  oTX_DATA;
    logic        oBUSY;

    always #5 CLK = ~CLK;

    uart_tx_arbiter #(
        .NUM_REQ       (2),
        .OVER_SAMPLING (4),
        .GUARD_CYCLES  (4),
        .DE_CYCLES     (2)
    ) u_dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .iSEVEN_BIT (iSEVEN_BIT),
        .iPARITY_EN (iPARITY_EN),
        .iSTOP_BIT  (iSTOP_BIT),
        .iREQ       (iREQ),
        .iDATA      (iDATA),
        .oACK       (oACK),
        .oTX_DE     (oTX_DE),
        .oTX_DATA   (oTX_DATA),
        .oBUSY      (oBUSY)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [1:0] lg_ack  [0:15];
    logic [7:0] lg_data [0:15];
    int         lg_cyc  [0:15];
    int         lg_rise [0:15];
    int         lg_n_ack, lg_n_rise, lg_de_hi, lg_busy_hi, lg_now;
    logic       lg_prev_de;

    // Grant period (SLOT+1) per format {seven, parity, stop}, OS=4, guard=4
    int exp_period [0:7] = '{45, 49, 49, 53, 41, 45, 45, 49};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_fmt(input logic [2:0] f);
        {iSEVEN_BIT, iPARITY_EN, iSTOP_BIT} = f;
    endtask

    task automatic clear_log();
        lg_n_ack   = 0;
        lg_n_rise  = 0;
        lg_de_hi   = 0;
        lg_busy_hi = 0;
        lg_now     = 0;
        lg_prev_de = oTX_DE;
    endtask

    task automatic observe(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            lg_now++;
            if (oACK != 2'b00 && lg_n_ack < 16) begin
                lg_ack[lg_n_ack]  = oACK;
                lg_data[lg_n_ack] = oTX_DATA;
                lg_cyc[lg_n_ack]  = lg_now;
                lg_n_ack++;
            end
            if (oTX_DE && !lg_prev_de && lg_n_rise < 16) begin
                lg_rise[lg_n_rise] = lg_now;
                lg_n_rise++;
            end
            lg_prev_de = oTX_DE;
            if (oTX_DE) lg_de_hi++;
            if (oBUSY)  lg_busy_hi++;
        end
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        iREQ  = 2'b00;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"},  32'(oACK),     32'h0);
        check({tag, "_de"},   32'(oTX_DE),   32'h0);
        check({tag, "_data"}, 32'(oTX_DATA), 32'hFF);
        check({tag, "_busy"}, 32'(oBUSY),    32'h0);
    endtask

    initial begin
        RST_N = 1'b0;
        iREQ  = 2'b00;
        iDATA = 16'h0000;
        set_fmt(3'b000);

        // Reset values, then one 8N1 byte from requester 0
        repeat (2) @(negedge CLK);
        check_reset_outputs("rst");
        RST_N = 1'b1;
        iREQ  = 2'b01;
        iDATA = 16'h00A5;
        clear_log();
        observe(1);
        check("t1_ack",  32'(oACK),     32'h1);
        check("t1_data", 32'(oTX_DATA), 32'hA5);
        check("t1_de",   32'(oTX_DE),   32'h1);
        check("t1_busy", 32'(oBUSY),    32'h1);
        iREQ = 2'b00;
        observe(59);
        check("t1_n_ack",   32'(lg_n_ack),   32'd1);
        check("t1_de_hi",   32'(lg_de_hi),   32'd2);
        check("t1_busy_hi", 32'(lg_busy_hi), 32'd44);
        check("t1_hold",    32'(oTX_DATA),   32'hA5);

        // Both requesters held: strict alternation, 45-cycle spacing
        apply_reset();
        iREQ  = 2'b11;
        iDATA = 16'h2211;
        clear_log();
        observe(180);
        iREQ = 2'b00;
        check("t2_n_ack",  32'(lg_n_ack),  32'd4);
        check("t2_n_rise", 32'(lg_n_rise), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t2_ack",  32'(lg_ack[i]),  (i % 2 == 1) ? 32'h2 : 32'h1);
            check("t2_data", 32'(lg_data[i]), (i % 2 == 1) ? 32'h22 : 32'h11);
        end
        for (int i = 1; i < 4; i++) begin
            check("t2_rise_gap", 32'(lg_rise[i] - lg_rise[i-1]), 32'd45);
        end

        // 7E2 slot, with a format change mid-slot taking effect next slot
        apply_reset();
        set_fmt(3'b111);
        iREQ  = 2'b01;
        iDATA = 16'h005A;
        clear_log();
        observe(10);
        set_fmt(3'b000);
        observe(100);
        iREQ = 2'b00;
        check("t3_n_ack", 32'(lg_n_ack), 32'd3);
        check("t3_gap0",  32'(lg_cyc[1] - lg_cyc[0]), 32'd49);
        check("t3_gap1",  32'(lg_cyc[2] - lg_cyc[1]), 32'd45);
        check("t3_data",  32'(lg_data[2]), 32'h5A);

        // Short request pulse during SEND is never served
        apply_reset();
        iREQ  = 2'b01;
        iDATA = 16'h3C77;
        clear_log();
        observe(1);
        iREQ = 2'b00;
        observe(5);
        iREQ = 2'b10;
        observe(1);
        iREQ = 2'b00;
        observe(60);
        check("t4_n_ack",   32'(lg_n_ack),   32'd1);
        check("t4_ack",     32'(lg_ack[0]),  32'h1);
        check("t4_busy_hi", 32'(lg_busy_hi), 32'd44);

        // Asynchronous reset mid-slot, pointer restarts at requester 0
        apply_reset();
        iREQ  = 2'b11;
        iDATA = 16'h2211;
        clear_log();
        observe(1);
        check("t5_first", 32'(oACK), 32'h1);
        observe(9);
        observe(1);
        #2;
        RST_N = 1'b0;
        #1;
        check_reset_outputs("t5_async");
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        clear_log();
        observe(1);
        check("t5_ack",  32'(oACK),     32'h1);
        check("t5_data", 32'(oTX_DATA), 32'h11);
        observe(46);
        iREQ = 2'b00;
        check("t5_n_ack", 32'(lg_n_ack), 32'd2);
        check("t5_gap",   32'(lg_cyc[1] - lg_cyc[0]), 32'd45);
        check("t5_ack2",  32'(lg_ack[1]), 32'h2);

        // Every frame format: requester 1 alone, grant period SLOT+1
        for (int f = 0; f < 8; f++) begin
            apply_reset();
            set_fmt(3'(f));
            iREQ  = 2'b10;
            iDATA = {8'(8'h30 + f), 8'h00};
            clear_log();
            observe(2 * exp_period[f]);
            iREQ = 2'b00;
            check("fmt_n_ack", 32'(lg_n_ack), 32'd2);
            check("fmt_gap",   32'(lg_cyc[1] - lg_cyc[0]), 32'(exp_period[f]));
            check("fmt_ack",   32'(lg_ack[0]), 32'h2);
            check("fmt_data",  32'(lg_data[0]), 32'(8'h30 + f));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART_TX_CORE instance between NUM_REQ byte sources, such as the coordinate reporter and the status/debug reporter, using round-robin arbitration.
- Drives the core's iDE/iDATA pair.
- Holds iDATA stable for the whole character, because the core samples iDATA after the DE rising edge and recomputes parity from live iDATA.
- Paces back-to-back bytes from a cycle count derived from the frame format, because the core has no busy output.
- Sits between the requesters and UART_TX_CORE; the frame-format inputs are the same ones wired to the core.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- OVER_SAMPLING, 4, clocks per UART bit; must match the core's parameter.
- GUARD_CYCLES, 4, idle clocks added after each character slot; must be at least 1.
- DE_CYCLES, 2, clocks oTX_DE is held high per byte; 1..4, must be less than the slot length.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- iSEVEN_BIT  in  1  1 = 7 data bits, 0 = 8.
- iPARITY_EN  in  1  1 = parity bit present.
- iSTOP_BIT  in  1  1 = 2 stop bits, 0 = 1.
- iREQ  in  NUM_REQ  per-requester request, level.
- iDATA  in  8*NUM_REQ  requester byte; requester i occupies bits [8i+7:8i].
- oACK  out  NUM_REQ  one-cycle grant/consume pulse.
- oTX_DE  out  1  to the core's iDE.
- oTX_DATA  out  8  to the core's iDATA.
- oBUSY  out  1  high while a character slot is in progress.

Behaviour:
Clock and reset
- One clock (CLK). Reset RST_N is asynchronous and active-low.
- Reset values: state IDLE, oACK = 0, oTX_DE = 0, oTX_DATA = 8'hFF, oBUSY = 0, slot counter = 0, round-robin pointer = NUM_REQ-1 (so requester 0 wins first).
- Reset asserted mid-slot aborts the slot immediately; outputs return to their reset values.

Slot length
- SLOT = (1 + (iSEVEN_BIT ? 7 : 8) + iPARITY_EN + (iSTOP_BIT ? 2 : 1)) * OVER_SAMPLING + GUARD_CYCLES.
- Computed at unsigned width clog2(12*OVER_SAMPLING + GUARD_CYCLES) + 1 bits, so it cannot overflow.
- Format inputs are sampled only at the grant edge; changes during a slot do not alter the current slot.
- Format inputs must be static while oBUSY = 1, since the core reads them live.

State machine (IDLE, SEND)
- IDLE, no iREQ bit set: hold; oACK = 0.
- IDLE, any iREQ bit set at a rising edge (edge E):
  - Winner = first set bit searching pointer+1, pointer+2, ... modulo NUM_REQ.
  - At E: register oACK[winner] = 1, oTX_DATA = winner's byte, oTX_DE = 1, counter = SLOT-1, pointer = winner; go to SEND.
  - The one-cycle oACK pulse is the only output of the grant decision; the requester's byte is consumed on that edge.
- SEND:
  - oACK = 0.
  - oTX_DE stays 1 for exactly DE_CYCLES cycles after E, then 0 for the rest of the slot. This guarantees a falling edge before the next rising edge.
  - Counter decrements once per cycle.
  - When counter = 0, go to IDLE; oTX_DE = 0, and oTX_DATA keeps its value.
- SEND lasts exactly SLOT cycles; oBUSY = 1 during SEND. Back-to-back DE rising edges are spaced SLOT+1 cycles.
- iREQ is level-sensitive and never latched: a request dropped before the grant edge is not served. A requester holding iREQ after its oACK is treated as a new byte request.
- iREQ changes during SEND are ignored until IDLE.
- With a single requester, back-to-back bytes are served every SLOT+1 cycles.
- With all requesters active, service order is strict rotation 0, 1, ..., NUM_REQ-1, 0, ...
- oTX_DATA changes only at grant edges.

Test Plan:
1. Reset with iREQ = 2'b00 → all outputs at reset values; then iREQ = 2'b01, iDATA[7:0] = 8'hA5 at 8N1 → oACK = 01 for 1 cycle, oTX_DATA = 8'hA5, oTX_DE high exactly 2 cycles, oBUSY high exactly 44 cycles.
2. Both requesters held high, bytes 8'h11 and 8'h22, 8N1 → oTX_DATA alternates 11, 22, 11, 22; DE rising edges every 45 cycles; oACK pulses alternate 01, 10.
3. 7E2 (iSEVEN_BIT = 1, iPARITY_EN = 1, iSTOP_BIT = 1), single requester → SLOT = 48, period 49; changing format mid-slot leaves that slot at 48.
4. Requester 1 pulses iREQ for 1 cycle during SEND, then drops it → never acknowledged; no extra slot.
5. RST_N low at cycle 10 of a slot, with iREQ still high → outputs reset asynchronously; after release, requester 0 is granted first and a full fresh slot follows.
6. Loopback with UART_TX_CORE plus a UART RX model, 50 random bytes from 2 requesters across all 8 format combinations → every byte received intact with correct parity and no framing errors.
